prog_loader: RTL and testbench

- Upstream boot stage for the VeriRISC cpu. It receives a program as a byte stream over a valid/ready handshake and writes it into the cpu's 32x8 instruction/data memory.
- It then holds cpu reset for a fixed number of cycles and releases it.
- It watches HALT, reports completion and counts the run cycles.
- It replaces file-based memory preload. Benches and a future UART front-end feed it directly.

---
 rtl/prog_loader.sv | 175 +++++++++++++++++
 tb/tb_prog_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Purpose: boot loader for the VeriRISC cpu; streams a program into the 32x8 memory, holds cpu reset, runs to HALT.
// Latency: an accepted byte is written one cycle later; CPU_RST stays high RST_CYCLES cycles after the last write.
// Backpressure: IN_READY is high only in LOAD while bytes remain outstanding; IN_VALID without IN_READY is ignored.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN builds the CHKSUM accumulator; otherwise CHKSUM is tied to 0.
// Ports: CLK/RST (async active-low) clock and reset; START/LEN kick off a sequence; IN_VALID/IN_DATA/IN_READY
//        byte stream; MEM_WR/MEM_ADDR/MEM_DATA memory write port; CPU_RST cpu reset; HALT cpu halt flag;
//        BUSY/DONE status; CYCLES saturating run-cycle count; CHKSUM modulo-256 sum of loaded bytes.
module prog_loader #(
  parameter int AWIDTH     = 5,
  parameter int DWIDTH     = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [AWIDTH:0]   LEN,
  input  logic              IN_VALID,
  input  logic [DWIDTH-1:0] IN_DATA,
  output logic              IN_READY,
  output logic              MEM_WR,
  output logic [AWIDTH-1:0] MEM_ADDR,
  output logic [DWIDTH-1:0] MEM_DATA,
  output logic              CPU_RST,
  input  logic              HALT,
  output logic              BUSY,
  output logic              DONE,
  output logic [15:0]       CYCLES,
  output logic [DWIDTH-1:0] CHKSUM
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RSTCPU,
    ST_RUN,
    ST_HALTED
  } state_t;

  localparam logic [AWIDTH:0] DEPTH_L  = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] CNT_ONE  = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [3:0]      RST_LOAD = 4'(RST_CYCLES - 1);

  state_t              state, state_nxt;
  logic [AWIDTH:0]     len_q;
  logic [AWIDTH:0]     cnt;
  logic [AWIDTH:0]     len_in;
  logic [3:0]          rst_cnt;
  logic                halt_q;
  logic                halt_d;
  logic                halt_rise;
  logic                start_ok;
  logic                xfer;
  logic                last_xfer;
  logic [15:0]         cycles_q;
  logic                mem_wr_q;
  logic [AWIDTH-1:0]   mem_addr_q;
  logic [DWIDTH-1:0]   mem_data_q;

  // Lengths beyond the memory depth are clamped so addresses never wrap.
  assign len_in    = (LEN > DEPTH_L) ? DEPTH_L : LEN;
  assign start_ok  = START && ((state == ST_IDLE) || (state == ST_HALTED));
  assign xfer      = IN_VALID && IN_READY;
  assign last_xfer = xfer && ((cnt + CNT_ONE) == len_q);
  // halt_d is forced low outside RUN, so HALT already high on RUN entry still looks like a rising edge.
  assign halt_rise = halt_q && !halt_d;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (start_ok) begin
          state_nxt = (len_in == '0) ? ST_RSTCPU : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (last_xfer) begin
          state_nxt = ST_RSTCPU;
        end
      end
      ST_RSTCPU: begin
        if (rst_cnt == 4'd0) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (halt_rise) begin
          state_nxt = ST_HALTED;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    IN_READY = (state == ST_LOAD) && (cnt < len_q);
    CPU_RST  = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_RSTCPU);
    BUSY     = (state == ST_LOAD) || (state == ST_RSTCPU) || (state == ST_RUN);
    DONE     = (state == ST_HALTED);
  end

  // Datapath: byte counter, registered memory write, reset timer, halt edge detect, run counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      len_q      <= '0;
      cnt        <= '0;
      rst_cnt    <= RST_LOAD;
      halt_q     <= 1'b0;
      halt_d     <= 1'b0;
      cycles_q   <= 16'd0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      mem_wr_q <= 1'b0;
      if (start_ok) begin
        len_q    <= len_in;
        cnt      <= '0;
        cycles_q <= 16'd0;
      end
      if (xfer) begin
        mem_wr_q   <= 1'b1;
        mem_addr_q <= cnt[AWIDTH-1:0];
        mem_data_q <= IN_DATA;
        cnt        <= cnt + CNT_ONE;
      end
      // Reloading whenever outside RSTCPU means the timer is fresh on every entry.
      if (state != ST_RSTCPU) begin
        rst_cnt <= RST_LOAD;
      end else if (rst_cnt != 4'd0) begin
        rst_cnt <= rst_cnt - 4'd1;
      end
      halt_q <= HALT;
      halt_d <= (state == ST_RUN) && halt_q;
      // The count freezes on the halt edge itself.
      if ((state == ST_RUN) && !halt_rise && (cycles_q != 16'hFFFF)) begin
        cycles_q <= cycles_q + 16'd1;
      end
    end
  end

  assign MEM_WR   = mem_wr_q;
  assign MEM_ADDR = mem_addr_q;
  assign MEM_DATA = mem_data_q;
  assign CYCLES   = cycles_q;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DWIDTH-1:0] chksum_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      chksum_q <= '0;
    end else if (start_ok) begin
      chksum_q <= '0;
    end else if (xfer) begin
      chksum_q <= chksum_q + IN_DATA;
    end
  end

  assign CHKSUM = chksum_q;
`else
  assign CHKSUM = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [5:0]  LEN;
  logic        IN_VALID;
  logic [7:0]  IN_DATA;
  logic        IN_READY;
  logic        MEM_WR;
  logic [4:0]  MEM_ADDR;
  logic [7:0]  MEM_DATA;
  logic        CPU_RST;
  logic        HALT;
  logic        BUSY;
  logic        DONE;
  logic [15:0] CYCLES;
  logic [7:0]  CHKSUM;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  stim [0:31];
  logic [12:0] exp_q [$];
  logic [12:0] obs_q [$];

  prog_loader #(.AWIDTH(5), .DWIDTH(8), .RST_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .START(START), .LEN(LEN),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .MEM_WR(MEM_WR), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .CPU_RST(CPU_RST), .HALT(HALT), .BUSY(BUSY), .DONE(DONE),
    .CYCLES(CYCLES), .CHKSUM(CHKSUM)
  );

  always #5 CLK = ~CLK;

  // Collect every memory write the DUT issues.
  always @(negedge CLK) begin
    if (MEM_WR === 1'b1) obs_q.push_back({MEM_ADDR, MEM_DATA});
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference checksum of the first n stimulus bytes.
  function automatic logic [7:0] exp_sum(input int n);
    logic [7:0] s;
    s = 8'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
    for (int i = 0; i < n; i++) s = s + stim[i];
`endif
    return s;
  endfunction

  task automatic apply_reset();
    RST = 1'b0; START = 1'b0; IN_VALID = 1'b0; IN_DATA = 8'h00; HALT = 1'b0; LEN = 6'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    exp_q.delete();
    obs_q.delete();
    @(posedge CLK); #1;
  endtask

  task automatic start_seq(input logic [5:0] len);
    @(posedge CLK); #1;
    START = 1'b1; LEN = len;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  // Drives n bytes; every accepted byte pushes its expected write onto the scoreboard.
  task automatic stream_bytes(input int n, input bit toggle, output bit timeout);
    int idx;
    int k;
    bit pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    idx = 0; k = 0; timeout = 1'b0;
    while (idx < n) begin
      if (k >= 400) begin
        timeout = 1'b1;
        break;
      end
      IN_VALID = toggle ? pat[k % 6] : 1'b1;
      IN_DATA  = IN_VALID ? stim[idx] : 8'hEE;
      @(negedge CLK);
      if (IN_VALID && IN_READY) begin
        exp_q.push_back({idx[4:0], stim[idx]});
        idx++;
      end
      @(posedge CLK); #1;
      k++;
    end
    IN_VALID = 1'b0;
  endtask

  task automatic test_reset();
    logic [41:0] got;
    RST = 1'b0; START = 1'b1; LEN = 6'd3; IN_VALID = 1'b1; IN_DATA = 8'h55; HALT = 1'b0;
    repeat (3) @(posedge CLK); #1;
    got = {IN_READY, MEM_WR, MEM_ADDR, MEM_DATA, CPU_RST, BUSY, DONE, CYCLES, CHKSUM};
    n_cmp++;
    if (got !== {1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 16'd0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_values: got %h expected %h", got,
               {1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 16'd0, 8'd0});
    end
    START = 1'b0; IN_VALID = 1'b0;
  endtask

  task automatic test_basic();
    bit to;
    logic [12:0] e, o;
    apply_reset();
    stim[0] = 8'hA0; stim[1] = 8'h01; stim[2] = 8'hE0;
    start_seq(6'd3);
    stream_bytes(3, 1'b0, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL basic_timeout: load did not complete, got timeout expected none"); end
    @(negedge CLK);
    n_cmp++;
    if ({CPU_RST, IN_READY, BUSY, MEM_WR, MEM_ADDR} !== {3'b101, 1'b1, 5'd2}) begin
      n_err++;
      $display("FAIL basic_rst0: got rst/rdy/busy/wr/addr %b expected %b",
               {CPU_RST, IN_READY, BUSY, MEM_WR, MEM_ADDR}, {3'b101, 1'b1, 5'd2});
    end
    @(negedge CLK);
    n_cmp++;
    if (CPU_RST !== 1'b1) begin n_err++; $display("FAIL basic_rst1: got CPU_RST %b expected 1", CPU_RST); end
    @(negedge CLK);
    n_cmp++;
    if ({CPU_RST, BUSY} !== 2'b01) begin
      n_err++; $display("FAIL basic_run: got rst/busy %b expected 01", {CPU_RST, BUSY});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL basic_write: got no write expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL basic_write: got %h expected %h", o, e); end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL basic_extra: got %0d extra writes expected 0", obs_q.size()); end
    n_cmp++;
    if (CHKSUM !== exp_sum(3)) begin n_err++; $display("FAIL basic_chksum: got %h expected %h", CHKSUM, exp_sum(3)); end
    // START while running must be ignored; CYCLES keeps counting.
    start_seq(6'd5);
    @(negedge CLK);
    n_cmp++;
    if ({CPU_RST, IN_READY, DONE, BUSY, CYCLES} !== {4'b0001, 16'd2}) begin
      n_err++;
      $display("FAIL start_in_run: got %h expected %h", {CPU_RST, IN_READY, DONE, BUSY, CYCLES}, {4'b0001, 16'd2});
    end
  endtask

  task automatic test_toggle();
    bit to;
    logic [12:0] e, o;
    apply_reset();
    stim[0] = 8'hA0; stim[1] = 8'h01; stim[2] = 8'hE0;
    start_seq(6'd3);
    stream_bytes(3, 1'b1, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL toggle_timeout: load did not complete, got timeout expected none"); end
    // Valid held after the load must not produce further writes.
    IN_VALID = 1'b1; IN_DATA = 8'h5A;
    repeat (4) @(negedge CLK);
    IN_VALID = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL toggle_write: got no write expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL toggle_write: got %h expected %h", o, e); end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL toggle_extra: got %0d extra writes expected 0", obs_q.size()); end
    n_cmp++;
    if (CHKSUM !== exp_sum(3)) begin n_err++; $display("FAIL toggle_chksum: got %h expected %h", CHKSUM, exp_sum(3)); end
  endtask

  task automatic test_len0();
    apply_reset();
    start_seq(6'd0);
    @(negedge CLK);
    n_cmp++;
    if ({CPU_RST, BUSY, DONE, IN_READY} !== 4'b1100) begin
      n_err++; $display("FAIL len0_c1: got rst/busy/done/rdy %b expected 1100", {CPU_RST, BUSY, DONE, IN_READY});
    end
    @(negedge CLK);
    n_cmp++;
    if ({CPU_RST, BUSY, DONE} !== 3'b110) begin
      n_err++; $display("FAIL len0_c2: got rst/busy/done %b expected 110", {CPU_RST, BUSY, DONE});
    end
    @(negedge CLK);
    n_cmp++;
    if ({CPU_RST, BUSY, DONE} !== 3'b010) begin
      n_err++; $display("FAIL len0_c3: got rst/busy/done %b expected 010", {CPU_RST, BUSY, DONE});
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL len0_writes: got %0d writes expected 0", obs_q.size()); end
  endtask

  task automatic test_halt();
    bit seen;
    apply_reset();
    start_seq(6'd0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (CPU_RST === 1'b0) begin seen = 1'b1; break; end
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL halt_run_entry: got CPU_RST stuck 1 expected 0 within 20 cycles"); end
    @(posedge CLK);
    repeat (9) @(posedge CLK);
    #1;
    HALT = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({DONE, CYCLES} !== {1'b0, 16'd10}) begin
      n_err++; $display("FAIL halt_c0: got done/cycles %h expected %h", {DONE, CYCLES}, {1'b0, 16'd10});
    end
    @(negedge CLK);
    n_cmp++;
    if ({DONE, BUSY, CYCLES} !== {2'b01, 16'd11}) begin
      n_err++; $display("FAIL halt_c1: got done/busy/cycles %h expected %h", {DONE, BUSY, CYCLES}, {2'b01, 16'd11});
    end
    @(negedge CLK);
    n_cmp++;
    if ({DONE, BUSY, CPU_RST, CYCLES} !== {3'b100, 16'd11}) begin
      n_err++; $display("FAIL halt_c2: got done/busy/rst/cycles %h expected %h", {DONE, BUSY, CPU_RST, CYCLES}, {3'b100, 16'd11});
    end
    repeat (5) @(negedge CLK);
    n_cmp++;
    if ({DONE, CYCLES} !== {1'b1, 16'd11}) begin
      n_err++; $display("FAIL halt_hold: got done/cycles %h expected %h", {DONE, CYCLES}, {1'b1, 16'd11});
    end
    // Restart from HALTED with HALT still high: halts on the first RUN cycle.
    start_seq(6'd0);
    @(negedge CLK);
    n_cmp++;
    if ({DONE, BUSY, CPU_RST, CYCLES} !== {3'b011, 16'd0}) begin
      n_err++; $display("FAIL restart_clear: got done/busy/rst/cycles %h expected %h", {DONE, BUSY, CPU_RST, CYCLES}, {3'b011, 16'd0});
    end
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++;
    if ({DONE, CPU_RST} !== 2'b00) begin
      n_err++; $display("FAIL restart_run: got done/rst %b expected 00", {DONE, CPU_RST});
    end
    @(negedge CLK);
    n_cmp++;
    if ({DONE, CYCLES} !== {1'b1, 16'd0}) begin
      n_err++; $display("FAIL halt_on_entry: got done/cycles %h expected %h", {DONE, CYCLES}, {1'b1, 16'd0});
    end
    HALT = 1'b0;
  endtask

  task automatic test_full(input logic [5:0] len, input bit invert);
    bit to;
    logic [12:0] e, o;
    apply_reset();
    for (int i = 0; i < 32; i++) stim[i] = invert ? ~8'(i) : 8'(i);
    start_seq(len);
    stream_bytes(32, 1'b0, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL full_timeout: len %0d load did not complete, got timeout expected none", len); end
    IN_VALID = 1'b1; IN_DATA = 8'hC3;
    @(negedge CLK);
    n_cmp++;
    if ({MEM_WR, MEM_ADDR, MEM_DATA, IN_READY} !== {1'b1, 5'd31, stim[31], 1'b0}) begin
      n_err++;
      $display("FAIL full_last: got wr/addr/data/rdy %h expected %h", {MEM_WR, MEM_ADDR, MEM_DATA, IN_READY},
               {1'b1, 5'd31, stim[31], 1'b0});
    end
    repeat (3) @(negedge CLK);
    IN_VALID = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL full_write: got no write expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL full_write: got %h expected %h", o, e); end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL full_extra: got %0d extra writes expected 0", obs_q.size()); end
    n_cmp++;
    if (CHKSUM !== exp_sum(32)) begin n_err++; $display("FAIL full_chksum: got %h expected %h", CHKSUM, exp_sum(32)); end
  endtask

  task automatic test_reset_mid();
    bit to;
    logic [41:0] got;
    logic [12:0] e, o;
    apply_reset();
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44; stim[4] = 8'h55;
    start_seq(6'd5);
    IN_VALID = 1'b1; IN_DATA = stim[0];
    @(posedge CLK); #1;
    IN_DATA = stim[1];
    @(posedge CLK); #1;
    IN_DATA = stim[2];
    #1;
    RST = 1'b0;
    #1;
    got = {IN_READY, MEM_WR, MEM_ADDR, MEM_DATA, CPU_RST, BUSY, DONE, CYCLES, CHKSUM};
    n_cmp++;
    if (got !== {1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 16'd0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_mid: got %h expected %h", got, {1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 16'd0, 8'd0});
    end
    IN_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    exp_q.delete();
    obs_q.delete();
    stim[0] = 8'h66; stim[1] = 8'h77; stim[2] = 8'h88;
    start_seq(6'd3);
    stream_bytes(3, 1'b0, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL reset_restart_timeout: got timeout expected none"); end
    repeat (2) @(negedge CLK);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL reset_restart_write: got no write expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL reset_restart_write: got %h expected %h", o, e); end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL reset_restart_extra: got %0d extra writes expected 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_len0();
    test_halt();
    test_full(6'd32, 1'b0);
    test_full(6'd40, 1'b1);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
